// File: rtl/waveform_playback_sequencer_pkg.sv
// Shared definitions for the waveform playback sequencer: playback modes and
// sequencer state encodings.
package waveform_playback_sequencer_pkg;

  localparam logic [1:0] MODE_CONTINUOUS = 2'd0;
  localparam logic [1:0] MODE_ONESHOT    = 2'd1;
  localparam logic [1:0] MODE_BURST      = 2'd2;
  localparam logic [1:0] MODE_RESERVED   = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

endpackage

// File: rtl/waveform_playback_sequencer_pulse_delay_line.sv
// Fixed-latency pulse delay used to line markers up with memory and serializer
// latency. DELAY=0 is a straight pass-through.
module pulse_delay_line #(
  parameter int DELAY = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  if (DELAY == 0) begin : g_bypass
    assign out = in;
  end else begin : g_shift
    logic [DELAY-1:0] shift_q;
    logic [DELAY-1:0] shift_d;

    always_comb begin
      // NOTE: every bit is assigned on every pass through the block, so no latch can be inferred.
      shift_d[0] = in;
      for (int i = 1; i < DELAY; i++) begin
        shift_d[i] = shift_q[i-1];
      end
    end

    // NOTE: reset is applied to these flops so pending markers are flushed, not left to replay.
    always_ff @(posedge clock or posedge reset) begin
      // NOTE: non-blocking assignment so every stage samples its pre-edge neighbour.
      if (reset) shift_q <= '0;
      else       shift_q <= shift_d;
    end

    assign out = shift_q[DELAY-1];
  end

endmodule

// File: rtl/waveform_playback_sequencer.sv
// Read-address sequencer that plays a stored waveform from the RAM read port
// in continuous, one-shot or burst mode, with trigger/abort and a delayed sync marker.
module waveform_playback_sequencer
  import waveform_playback_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH   = 14,
  parameter int REPEAT_WIDTH = 16,
  parameter int SYNC_DELAY   = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   start_address,
  input  logic [ADDR_WIDTH-1:0]   end_address,
  input  logic [1:0]              mode,
  input  logic [REPEAT_WIDTH-1:0] repeat_count,
  input  logic                    trigger,
  input  logic                    abort,
  output logic [ADDR_WIDTH-1:0]   read_address,
  output logic                    read_enable,
  output logic                    busy,
  output logic                    sync_out,
  output logic                    done,
  output logic                    config_error
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   start_q, start_d;
  logic [ADDR_WIDTH-1:0]   end_q, end_d;
  logic [1:0]              mode_q, mode_d;
  logic [REPEAT_WIDTH-1:0] repeat_q, repeat_d;
  logic [REPEAT_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
  logic                    halted_q, halted_d;
  logic                    sync_raw_q, sync_raw_d;
  logic                    done_q, done_d;
  logic                    cfg_err_q, cfg_err_d;

  logic                    cfg_valid;
  logic [ADDR_WIDTH-1:0]   last_addr;
  logic                    last_word;
  logic                    start_pass;
  logic                    wrap;
  logic                    finish;

  assign cfg_valid = (end_address > start_address) && (mode != MODE_RESERVED);
  // Wraps modulo 2^ADDR_WIDTH; the latched config was valid, so it is never below start_q.
  assign last_addr = end_q - ADDR_WIDTH'(1);
  assign last_word = (addr_q == last_addr);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    start_d    = start_q;
    end_d      = end_q;
    mode_d     = mode_q;
    repeat_d   = repeat_q;
    pass_cnt_d = pass_cnt_q;
    halted_d   = halted_q;
    sync_raw_d = 1'b0;
    done_d     = 1'b0;
    cfg_err_d  = (end_address <= start_address);
    start_pass = 1'b0;
    wrap       = 1'b0;
    finish     = 1'b0;

    if (abort) begin
      state_d  = ST_IDLE;
      halted_d = 1'b1;
    end else if (trigger) begin
      halted_d = 1'b0;
      if (cfg_valid) begin
        start_pass = 1'b1;
        pass_cnt_d = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_IDLE) begin
      if (mode == MODE_CONTINUOUS && cfg_valid && !halted_q) begin
        start_pass = 1'b1;
        pass_cnt_d = '0;
      end
    end else if (!last_word) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
    end else begin
      case (mode_q)
        MODE_CONTINUOUS: wrap = 1'b1;
        MODE_BURST: begin
          if (pass_cnt_q == repeat_q) begin
            finish = 1'b1;
          end else begin
            wrap       = 1'b1;
            pass_cnt_d = pass_cnt_q + REPEAT_WIDTH'(1);
          end
        end
        default: finish = 1'b1;
      endcase
    end

    // An invalid config seen at a wrap stops playback silently.
    if (wrap) begin
      if (cfg_valid) start_pass = 1'b1;
      else           state_d    = ST_IDLE;
    end

    if (finish) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end

    if (start_pass) begin
      state_d    = ST_PLAY;
      addr_d     = start_address;
      start_d    = start_address;
      end_d      = end_address;
      mode_d     = mode;
      repeat_d   = repeat_count;
      sync_raw_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      start_q    <= '0;
      end_q      <= '0;
      mode_q     <= MODE_CONTINUOUS;
      repeat_q   <= '0;
      pass_cnt_q <= '0;
      halted_q   <= 1'b0;
      sync_raw_q <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      start_q    <= start_d;
      end_q      <= end_d;
      mode_q     <= mode_d;
      repeat_q   <= repeat_d;
      pass_cnt_q <= pass_cnt_d;
      halted_q   <= halted_d;
      sync_raw_q <= sync_raw_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  pulse_delay_line #(
    .DELAY(SYNC_DELAY)
  ) u_sync_delay (
    .clock(clock),
    .reset(reset),
    .in   (sync_raw_q),
    .out  (sync_out)
  );

  assign read_address = addr_q;
  assign read_enable  = (state_q == ST_PLAY);
  assign busy         = (state_q == ST_PLAY);
  assign done         = done_q;
  assign config_error = cfg_err_q;

endmodule

// File: tb/tb_waveform_playback_sequencer.sv
// Scoreboard bench for waveform_playback_sequencer: each cycle's expected outputs
// are queued as stimulus is driven and compared at the following falling edge.
module tb_waveform_playback_sequencer;

  localparam int AW = 14;
  localparam int RW = 16;
  localparam int SD = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] start_address;
  logic [AW-1:0] end_address;
  logic [1:0]    mode;
  logic [RW-1:0] repeat_count;
  logic          trigger;
  logic          abort;
  logic [AW-1:0] read_address;
  logic          read_enable;
  logic          busy;
  logic          sync_out;
  logic          done;
  logic          config_error;

  waveform_playback_sequencer #(
    .ADDR_WIDTH  (AW),
    .REPEAT_WIDTH(RW),
    .SYNC_DELAY  (SD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start_address(start_address),
    .end_address  (end_address),
    .mode         (mode),
    .repeat_count (repeat_count),
    .trigger      (trigger),
    .abort        (abort),
    .read_address (read_address),
    .read_enable  (read_enable),
    .busy         (busy),
    .sync_out     (sync_out),
    .done         (done),
    .config_error (config_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic          ren;
    logic          sync;
    logic          done;
    logic          cfg;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_errors = 0;
  logic [SD-1:0] raw_hist = '0;
  logic          cfg_bad  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: queue what the DUT must show after this edge, then drive the
  // trigger/abort that the following edge will sample.
  task automatic tick(input logic [AW-1:0] a, input logic ren, input logic raw,
                      input logic dn, input logic trig, input logic ab);
    exp_t e;
    @(posedge clock);
    #1;
    e.addr = a;
    e.ren  = ren;
    e.done = dn;
    e.cfg  = cfg_bad;
    e.sync = raw_hist[SD-1];
    raw_hist = {raw_hist[SD-2:0], raw};
    sb.push_back(e);
    trigger = trig;
    abort   = ab;
  endtask

  task automatic play(input logic [AW-1:0] a, input logic raw);
    tick(a, 1'b1, raw, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic [AW-1:0] a, input logic dn);
    tick(a, 1'b0, 1'b0, dn, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 32'(read_address), 32'd0);
    check({tag, "_ren"},  32'(read_enable),  32'd0);
    check({tag, "_busy"}, 32'(busy),         32'd0);
    check({tag, "_sync"}, 32'(sync_out),     32'd0);
    check({tag, "_done"}, 32'(done),         32'd0);
    check({tag, "_cerr"}, 32'(config_error), 32'd0);
  endtask

  always @(negedge clock) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check("addr", 32'(read_address), 32'(mon_e.addr));
      check("ren",  32'(read_enable),  32'(mon_e.ren));
      check("busy", 32'(busy),         32'(mon_e.ren));
      check("sync", 32'(sync_out),     32'(mon_e.sync));
      check("done", 32'(done),         32'(mon_e.done));
      check("cerr", 32'(config_error), 32'(mon_e.cfg));
    end
  end

  initial begin
    reset         = 1'b0;
    trigger       = 1'b0;
    abort         = 1'b0;
    mode          = 2'd0;
    start_address = AW'(4);
    end_address   = AW'(8);
    repeat_count  = '0;
    #1 reset = 1'b1;
    #1 check_all_zero("reset");

    // Continuous 4..7 straight out of reset, then config changes at pass boundaries.
    idle(0, 0);
    reset = 1'b0;
    play(4, 1); play(5, 0); play(6, 0); play(7, 0);
    play(4, 1); play(5, 0); play(6, 0); play(7, 0);
    start_address = AW'(0); end_address = AW'(8);
    play(0, 1); play(1, 0); play(2, 0); play(3, 0);
    start_address = AW'(2); end_address = AW'(4);
    play(4, 0); play(5, 0); play(6, 0); play(7, 0);
    play(2, 1); play(3, 0); play(2, 1); play(3, 0);
    start_address = AW'(0); end_address = AW'(8);
    play(0, 1); play(1, 0); play(2, 0); play(3, 0);
    start_address = AW'(2); end_address = AW'(4);
    play(4, 0); play(5, 0);
    tick(6, 1, 0, 0, 1, 0);
    play(2, 1); play(3, 0);

    // Trigger and abort together: abort wins, continuous mode stays halted.
    tick(2, 1, 1, 0, 1, 1);
    idle(2, 0); idle(2, 0); idle(2, 0);
    tick(2, 0, 0, 0, 1, 0);
    play(2, 1); play(3, 0);
    tick(2, 1, 1, 0, 0, 1);
    idle(2, 0); idle(2, 0);

    // One-shot 10..12, replay, and restart on the last word without done.
    mode = 2'd1; start_address = AW'(10); end_address = AW'(13);
    idle(2, 0);
    tick(2, 0, 0, 0, 1, 0);
    play(10, 1); play(11, 0); play(12, 0);
    idle(12, 1); idle(12, 0);
    tick(12, 0, 0, 0, 1, 0);
    play(10, 1); play(11, 0);
    tick(12, 1, 0, 0, 1, 0);
    play(10, 1); play(11, 0); play(12, 0);
    idle(12, 1); idle(12, 0);

    // Burst of three passes, then a single-pass burst.
    mode = 2'd2; start_address = AW'(0); end_address = AW'(2); repeat_count = RW'(2);
    tick(12, 0, 0, 0, 1, 0);
    play(0, 1); play(1, 0); play(0, 1); play(1, 0); play(0, 1); play(1, 0);
    idle(1, 1); idle(1, 0); idle(1, 0); idle(1, 0);
    repeat_count = RW'(0);
    tick(1, 0, 0, 0, 1, 0);
    play(0, 1); play(1, 0);
    idle(1, 1); idle(1, 0);

    // Empty range: trigger ignored, config_error held.
    mode = 2'd1; start_address = AW'(5); end_address = AW'(5); cfg_bad = 1'b1;
    tick(1, 0, 0, 0, 1, 0);
    idle(1, 0); idle(1, 0); idle(1, 0);

    // Single-word continuous pass, then the range turns invalid at the wrap.
    mode = 2'd0; start_address = AW'(9); end_address = AW'(10); cfg_bad = 1'b0;
    play(9, 1); play(9, 1); play(9, 1); play(9, 1); play(9, 1);
    end_address = AW'(9); cfg_bad = 1'b1;
    idle(9, 0); idle(9, 0); idle(9, 0); idle(9, 0);

    // Asynchronous reset in the middle of a burst flushes pending sync pulses.
    mode = 2'd2; start_address = AW'(0); end_address = AW'(2); repeat_count = RW'(5);
    cfg_bad = 1'b0;
    tick(9, 0, 0, 0, 1, 0);
    play(0, 1); play(1, 0); play(0, 1); play(1, 0); play(0, 1);
    @(negedge clock);
    #1 reset = 1'b1;
    #1 check_all_zero("async_rst");
    raw_hist = '0;
    idle(0, 0);
    reset = 1'b0;
    idle(0, 0); idle(0, 0); idle(0, 0); idle(0, 0); idle(0, 0);

    @(negedge clock);
    #1 check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
